put_get_channel: RTL and testbench

Execution unit for the custom-opcode (CUSTOM_T) put/get instructions. A put (fn3 = put_fn3) sends rs1 onto an outbound message link. A get (fn3 = get_fn3) pops one word from an inbound message FIFO and returns it to writeback, blocking while the FIFO is empty. It sits beside the ALU/LS units on the issue bus and is the consuming end of the same inter-core link whose producing end is another core's put path.

---
 rtl/put_get_channel_pkg.sv | 29 ++
 rtl/put_get_channel_fifo.sv | 69 ++++++
 rtl/put_get_channel.sv | 165 ++++++++++++++++
 tb/tb_put_get_channel.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/put_get_channel_pkg.sv
// Shared types for the put/get channel unit: instruction encodings,
// get-FSM states and default channel sizing.
package put_get_channel_pkg;

    // Major opcode that carries put/get instructions.
    localparam logic [6:0] CUSTOM_T = 7'b0001011;

    // fn3 encodings inside CUSTOM_T; 010..111 are reserved.
    typedef enum logic [2:0] {
        PUT_FN3 = 3'b000,
        GET_FN3 = 3'b001
    } put_get_arith_t;

    // Get-side FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        WB   = 2'd2
    } channel_state_t;

    localparam int DEFAULT_CHANNEL_DEPTH = 8;
    localparam int CHANNEL_DATA_W        = 32;

    // True for any fn3 that is neither put nor get.
    function automatic logic is_reserved_fn3(input logic [2:0] fn3);
        return fn3[2:1] != 2'b00;
    endfunction

endpackage

// File: rtl/put_get_channel_fifo.sv
// channel_fifo: synchronous FIFO holding inbound link words until a get
// consumes them. Head word is visible combinationally; pointers wrap
// modulo DEPTH (DEPTH must be a power of two).
module channel_fifo
    import put_get_channel_pkg::*;
#(
    parameter int DEPTH = DEFAULT_CHANNEL_DEPTH,
    parameter int WIDTH = CHANNEL_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A push while full is only legal when a pop frees the slot that cycle.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/put_get_channel.sv
// put_get_channel: execution unit for CUSTOM_T put/get. Puts drive a
// registered outbound link word; gets pop the inbound FIFO into a
// registered writeback slot, blocking in WAIT while the FIFO is empty.
//
// Handshakes: every channel (issue, wb, tx, rx) transfers on the cycle
// where its valid and ready are both high; valid never depends on ready
// of the same channel, and ready/ack seen while valid is low is ignored.
module put_get_channel
    import put_get_channel_pkg::*;
#(
    parameter int DEPTH = DEFAULT_CHANNEL_DEPTH,
    parameter int ID_W  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [2:0]      issue_fn3,
    input  logic [31:0]     issue_rs1,
    input  logic [ID_W-1:0] issue_id,
    output logic            wb_valid,
    input  logic            wb_ack,
    output logic [ID_W-1:0] wb_id,
    output logic [31:0]     wb_rd,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [31:0]     tx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    input  logic [31:0]     rx_data,
    output logic            illegal_fn3
);

    channel_state_t  state_q;
    channel_state_t  state_d;

    logic            accept;
    logic            put_acc;
    logic            get_acc;
    logic            rsvd_acc;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [31:0]     fifo_head;

    logic            tx_valid_q;
    logic [31:0]     tx_data_q;
    logic [31:0]     wb_rd_q;
    logic [ID_W-1:0] wb_id_q;
    logic            illegal_q;

    // Issue acceptance and decode of the accepted instruction.
    always_comb begin
        accept   = issue_valid && issue_ready;
        put_acc  = accept && (issue_fn3 == PUT_FN3);
        get_acc  = accept && (issue_fn3 == GET_FN3);
        rsvd_acc = accept && is_reserved_fn3(issue_fn3);
    end

    // Ready outputs are forced low while reset is held.
    assign issue_ready = !rst && (state_q == IDLE) && !tx_valid_q;
    assign rx_ready    = !rst && !fifo_full;
    assign fifo_push   = rx_valid && rx_ready;

    channel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHANNEL_DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rx_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Get FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Get FSM next state and FIFO pop; the pop always coincides with
    // capture of the head word into the writeback slot.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (get_acc) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = WB;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = WB;
                end
            end
            WB: begin
                if (wb_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writeback slot: id latched at get acceptance, data at the pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_id_q <= '0;
            wb_rd_q <= '0;
        end else begin
            if (get_acc) begin
                wb_id_q <= issue_id;
            end
            if (fifo_pop) begin
                wb_rd_q <= fifo_head;
            end
        end
    end

    // Outbound link register: loaded by a put, cleared after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (put_acc) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= issue_rs1;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    // One-cycle flag for a reserved fn3 accepted on the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= rsvd_acc;
        end
    end

    assign wb_valid    = (state_q == WB);
    assign wb_id       = wb_id_q;
    assign wb_rd       = wb_rd_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign illegal_fn3 = illegal_q;

endmodule

// File: tb/tb_put_get_channel.sv
// Testbench for put_get_channel: directed table and hand sequences for
// timing corners, then a transaction-level scoreboard under random traffic.
module tb_put_get_channel;
  import put_get_channel_pkg::*;

  localparam int DEPTH = 8;
  localparam int ID_W  = 3;

  logic            clk;
  logic            rst;
  logic            issue_valid;
  logic            issue_ready;
  logic [2:0]      issue_fn3;
  logic [31:0]     issue_rs1;
  logic [ID_W-1:0] issue_id;
  logic            wb_valid;
  logic            wb_ack;
  logic [ID_W-1:0] wb_id;
  logic [31:0]     wb_rd;
  logic            tx_valid;
  logic            tx_ready;
  logic [31:0]     tx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic [31:0]     rx_data;
  logic            illegal_fn3;

  put_get_channel #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_fn3   (issue_fn3),
    .issue_rs1   (issue_rs1),
    .issue_id    (issue_id),
    .wb_valid    (wb_valid),
    .wb_ack      (wb_ack),
    .wb_id       (wb_id),
    .wb_rd       (wb_rd),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .illegal_fn3 (illegal_fn3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- counters and scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0]     exp_rd_q[$];
  logic [31:0]     exp_tx_q[$];
  logic [ID_W-1:0] exp_id_q[$];

  int n_push;
  int n_pop;
  int n_get_acc;
  logic exp_ill;
  logic p_wbv, p_ack, p_tv, p_txr;
  logic [31:0] p_rd, p_td;
  logic [ID_W-1:0] p_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_fn3   = 3'b000;
    issue_rs1   = '0;
    issue_id    = '0;
    wb_ack      = 1'b0;
    tx_ready    = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_issue_ready"}, issue_ready, 0);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_illegal"}, illegal_fn3, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_wb_rd"}, wb_rd, 0);
    chk({tag, "_wb_id"}, wb_id, 0);
  endtask

  // Reset, then clear the scoreboard to match an empty channel.
  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_rd_q.delete();
    exp_tx_q.delete();
    exp_id_q.delete();
    n_push = 0; n_pop = 0; n_get_acc = 0;
    exp_ill = 1'b0;
    p_wbv = 0; p_ack = 0; p_tv = 0; p_txr = 0;
    p_rd = '0; p_td = '0; p_id = '0;
  endtask

  // Transaction-level reference: FIFO order, occupancy = pushes - pops,
  // put payload order, and illegal pulse one cycle after a reserved accept.
  // Called once per cycle after inputs are driven and settled.
  task automatic monitor();
    int occ;
    chk("illegal_fn3", illegal_fn3, exp_ill);
    if (p_wbv && p_ack) begin
      chk("wb_after_ack", wb_valid, 0);
    end else if (p_wbv) begin
      chk("wb_hold_valid", wb_valid, 1);
      chk("wb_hold_rd", wb_rd, p_rd);
      chk("wb_hold_id", wb_id, p_id);
    end else if (wb_valid) begin
      n_pop++;
      if (exp_rd_q.size() == 0 || exp_id_q.size() == 0) begin
        fail_now("wb_unexpected_completion");
      end else begin
        chk("wb_rd", wb_rd, exp_rd_q.pop_front());
        chk("wb_id", wb_id, exp_id_q.pop_front());
      end
    end
    occ = n_push - n_pop;
    chk("rx_ready_vs_occupancy", rx_ready, occ < DEPTH);
    if (p_tv && !p_txr) begin
      chk("tx_hold_valid", tx_valid, 1);
      chk("tx_hold_data", tx_data, p_td);
    end
    if (tx_valid && tx_ready) begin
      if (exp_tx_q.size() == 0) fail_now("tx_unexpected_word");
      else chk("tx_data", tx_data, exp_tx_q.pop_front());
    end
    if (tx_valid || wb_valid) chk("issue_ready_busy", issue_ready, 0);
    exp_ill = 1'b0;
    if (issue_valid && issue_ready) begin
      if (issue_fn3 == 3'b000) exp_tx_q.push_back(issue_rs1);
      else if (issue_fn3 == 3'b001) begin
        exp_id_q.push_back(issue_id);
        n_get_acc++;
      end else exp_ill = 1'b1;
    end
    if (rx_valid && rx_ready) begin
      exp_rd_q.push_back(rx_data);
      n_push++;
    end
    p_wbv = wb_valid; p_ack = wb_ack; p_rd = wb_rd; p_id = wb_id;
    p_tv = tx_valid; p_txr = tx_ready; p_td = tx_data;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        iv;
    logic [2:0]  fn3;
    logic [31:0] rs1;
    logic        txr;
    logic        e_ir;
    logic        e_tv;
    logic        chk_td;
    logic [31:0] e_td;
    logic        e_ill;
    logic        e_wv;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] words[28];

  initial begin
    // Put with 3 cycles of back-pressure, then a reserved fn3.
    vecs[0] = '{1'b1, 3'b000, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b0, 3'b000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 3'b000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 3'b000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 3'b000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 3'b000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[6] = '{1'b1, 3'b101, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[7] = '{1'b0, 3'b000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[8] = '{1'b0, 3'b000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    for (int i = 0; i < 28; i++) words[i] = 32'hC0DE_0000 | i;

    // Power-on reset.
    idle_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk_all_zero("por");
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("por_release_issue_ready", issue_ready, 1);
    chk("por_release_rx_ready", rx_ready, 1);

    // Table: put back-pressure and reserved fn3.
    for (int i = 0; i < 9; i++) begin
      tick();
      issue_valid = vecs[i].iv;
      issue_fn3   = vecs[i].fn3;
      issue_rs1   = vecs[i].rs1;
      tx_ready    = vecs[i].txr;
      #1;
      chk($sformatf("vec%0d_issue_ready", i), issue_ready, vecs[i].e_ir);
      chk($sformatf("vec%0d_tx_valid", i), tx_valid, vecs[i].e_tv);
      if (vecs[i].chk_td) chk($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].e_td);
      chk($sformatf("vec%0d_illegal", i), illegal_fn3, vecs[i].e_ill);
      chk($sformatf("vec%0d_wb_valid", i), wb_valid, vecs[i].e_wv);
    end
    idle_inputs();

    // Get hit: two words queued, two gets with wb_ack held high.
    tick(); rx_valid = 1'b1; rx_data = 32'h11; #1 chk("hit_push0_ready", rx_ready, 1);
    tick(); rx_data = 32'h22; #1 chk("hit_push1_ready", rx_ready, 1);
    tick(); rx_valid = 1'b0; wb_ack = 1'b1;
    issue_valid = 1'b1; issue_fn3 = GET_FN3; issue_id = 3'd1;
    #1 chk("hit_accept0_ready", issue_ready, 1);
    tick(); issue_valid = 1'b0; #1;
    chk("hit0_wb_valid", wb_valid, 1);
    chk("hit0_wb_rd", wb_rd, 32'h11);
    chk("hit0_wb_id", wb_id, 1);
    chk("hit0_issue_ready", issue_ready, 0);
    tick(); issue_valid = 1'b1; issue_id = 3'd2; #1;
    chk("hit_gap_wb_valid", wb_valid, 0);
    chk("hit_gap_issue_ready", issue_ready, 1);
    tick(); issue_valid = 1'b0; #1;
    chk("hit1_wb_valid", wb_valid, 1);
    chk("hit1_wb_rd", wb_rd, 32'h22);
    chk("hit1_wb_id", wb_id, 2);
    tick(); wb_ack = 1'b0; #1;
    chk("hit_done_wb_valid", wb_valid, 0);
    chk("hit_done_issue_ready", issue_ready, 1);

    // Get miss: word arrives 5 cycles after the get, result at K+2.
    tick(); issue_valid = 1'b1; issue_fn3 = GET_FN3; issue_id = 3'd5;
    #1 chk("miss_accept_ready", issue_ready, 1);
    for (int i = 1; i < 5; i++) begin
      tick(); issue_valid = 1'b0; #1;
      chk($sformatf("miss_wait%0d_wb_valid", i), wb_valid, 0);
      chk($sformatf("miss_wait%0d_issue_ready", i), issue_ready, 0);
    end
    tick(); rx_valid = 1'b1; rx_data = 32'hA5A5A5A5; #1;
    chk("miss_k_rx_ready", rx_ready, 1);
    chk("miss_k_wb_valid", wb_valid, 0);
    tick(); rx_valid = 1'b0; #1;
    chk("miss_k1_wb_valid", wb_valid, 0);
    tick(); wb_ack = 1'b1; #1;
    chk("miss_k2_wb_valid", wb_valid, 1);
    chk("miss_k2_wb_rd", wb_rd, 32'hA5A5A5A5);
    chk("miss_k2_wb_id", wb_id, 5);
    tick(); wb_ack = 1'b0; #1;
    chk("miss_done_wb_valid", wb_valid, 0);
    chk("miss_done_issue_ready", issue_ready, 1);

    // Reset in the middle of a blocked get.
    tick(); issue_valid = 1'b1; issue_fn3 = GET_FN3; issue_id = 3'd3;
    #1 chk("rstwait_accept_ready", issue_ready, 1);
    tick(); issue_valid = 1'b0; #1 chk("rstwait_pre_wb_valid", wb_valid, 0);
    tick(); rst = 1'b1; #1 chk_all_zero("rstwait_in0");
    tick(); #1 chk_all_zero("rstwait_in1");
    tick(); rst = 1'b0; #1;
    chk("rstwait_release_issue_ready", issue_ready, 1);
    chk("rstwait_release_rx_ready", rx_ready, 1);
    chk("rstwait_release_wb_valid", wb_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1 chk($sformatf("rstwait_after%0d_wb_valid", i), wb_valid, 0);
    end

    // Fill to full, then alternate gets and pushes across the wrap.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tick(); rx_valid = 1'b1; rx_data = words[i]; #1;
      monitor();
    end
    begin
      int idx;
      int cyc;
      idx = 8;
      cyc = 0;
      tick(); rx_valid = 1'b1; rx_data = words[8]; #1;
      chk("full_rx_ready", rx_ready, 0);
      monitor();
      while (n_pop < 28 && cyc < 400) begin
        tick();
        cyc++;
        issue_valid = (n_get_acc < 28);
        issue_fn3   = GET_FN3;
        issue_id    = ID_W'($urandom);
        wb_ack      = 1'b1;
        rx_valid    = (idx < 28);
        rx_data     = (idx < 28) ? words[idx] : 32'h0;
        #1;
        monitor();
        if (rx_valid && rx_ready) idx++;
      end
      if (n_pop < 28) fail_now("wrap_timeout");
      chk("wrap_words_pushed", idx, 28);
      chk("wrap_rd_queue_empty", exp_rd_q.size(), 0);
      chk("wrap_id_queue_empty", exp_id_q.size(), 0);
    end

    // Random traffic against the scoreboard.
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      int r;
      tick();
      r = $urandom_range(0, 9);
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_fn3   = (r < 4) ? 3'b000 : (r < 8) ? 3'b001 : 3'($urandom_range(2, 7));
      issue_rs1   = $urandom;
      issue_id    = ID_W'($urandom);
      wb_ack      = ($urandom_range(0, 2) != 0);
      tx_ready    = ($urandom_range(0, 2) != 0);
      rx_valid    = ($urandom_range(0, 2) == 0);
      rx_data     = $urandom;
      #1;
      monitor();
    end
    begin
      int cyc;
      cyc = 0;
      while ((exp_id_q.size() > 0 || exp_tx_q.size() > 0 || p_wbv) && cyc < 300) begin
        tick();
        cyc++;
        issue_valid = 1'b0;
        tx_ready    = 1'b1;
        wb_ack      = 1'b1;
        rx_valid    = (exp_id_q.size() > exp_rd_q.size());
        rx_data     = $urandom;
        #1;
        monitor();
      end
      chk("drain_id_queue_empty", exp_id_q.size(), 0);
      chk("drain_tx_queue_empty", exp_tx_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
